rd_pointer_empty: RTL and testbench

//  Read-side pointer and empty-flag logic of the async FIFO; rclk-domain counterpart of the write pointer.

---
 rtl/rd_pointer_empty.sv | 100 ++++++++++
 tb/tb_rd_pointer_empty.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rd_pointer_empty.sv
// Read-side pointer, write-pointer synchroniser and registered empty/valid/underflow flags of an
// async FIFO. Define ASYNC_FIFO_RD_LEVEL_EN to add the registered rd_level and almost_empty outputs.
module rd_pointer_empty #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic           rclk,
  input  logic           rd_srstn,
  input  logic           rd_en,
  input  logic [WIDTH:0] wptr_gray_async,
  output logic [WIDTH-1:0] rd_addr,
  output logic [WIDTH:0] rd_ptr,
  output logic [WIDTH:0] rd_ptr_gray,
  output logic           empty,
  output logic           rd_valid,
  output logic           underflow
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  ,
  output logic [WIDTH:0] rd_level,
  output logic           almost_empty
`endif
);

  logic [WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0] rd_gray_q, rd_gray_d;
  logic [WIDTH:0] wsync1_q, wsync2_q;
  logic           empty_q, empty_d;
  logic           rd_valid_q, underflow_q;
  logic           rd_ready;

  assign rd_ready = rd_en & rd_srstn & ~empty_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    if (rd_ready) begin
      rd_ptr_d = rd_ptr_q + (WIDTH + 1)'(1);
    end
    rd_gray_d = rd_ptr_d ^ (rd_ptr_d >> 1);
    // Compare against the post-read pointer so the last read raises empty on the same edge.
    empty_d   = (rd_gray_d == wsync2_q);
  end

  always_ff @(posedge rclk) begin
    if (!rd_srstn) begin
      rd_ptr_q    <= '0;
      rd_gray_q   <= '0;
      wsync1_q    <= '0;
      wsync2_q    <= '0;
      empty_q     <= 1'b1;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_gray_q   <= rd_gray_d;
      wsync1_q    <= wptr_gray_async;
      wsync2_q    <= wsync1_q;
      empty_q     <= empty_d;
      rd_valid_q  <= rd_ready;
      underflow_q <= rd_en & empty_q;
    end
  end

  assign rd_addr     = rd_ptr_q[WIDTH-1:0];
  assign rd_ptr      = rd_ptr_q;
  assign rd_ptr_gray = rd_gray_q;
  assign empty       = empty_q;
  assign rd_valid    = rd_valid_q;
  assign underflow   = underflow_q;

`ifdef ASYNC_FIFO_RD_LEVEL_EN
  localparam logic [WIDTH:0] AeThresh = (WIDTH + 1)'(AE_THRESH);

  logic [WIDTH:0] wbin_sync;
  logic [WIDTH:0] level_q, level_d;
  logic           almost_empty_q;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_sync[WIDTH] = wsync2_q[WIDTH];
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      wbin_sync[i] = wbin_sync[i+1] ^ wsync2_q[i];
    end
    level_d = wbin_sync - rd_ptr_d;
  end

  always_ff @(posedge rclk) begin
    if (!rd_srstn) begin
      level_q        <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      level_q        <= level_d;
      almost_empty_q <= (level_d <= AeThresh);
    end
  end

  assign rd_level     = level_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_rd_pointer_empty.sv
// Directed bench for rd_pointer_empty at WIDTH=3, AE_THRESH=2.
module tb_rd_pointer_empty;

  localparam int unsigned W = 3;

  logic         rclk;
  logic         rd_srstn;
  logic         rd_en;
  logic [W:0]   wptr_gray_async;
  logic [W-1:0] rd_addr;
  logic [W:0]   rd_ptr;
  logic [W:0]   rd_ptr_gray;
  logic         empty;
  logic         rd_valid;
  logic         underflow;
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  logic [W:0]   rd_level;
  logic         almost_empty;
`endif

  int n_chk = 0;
  int n_bad = 0;

  rd_pointer_empty #(
    .WIDTH    (W),
    .AE_THRESH(2)
  ) dut (
    .rclk           (rclk),
    .rd_srstn       (rd_srstn),
    .rd_en          (rd_en),
    .wptr_gray_async(wptr_gray_async),
    .rd_addr        (rd_addr),
    .rd_ptr         (rd_ptr),
    .rd_ptr_gray    (rd_ptr_gray),
    .empty          (empty),
    .rd_valid       (rd_valid),
    .underflow      (underflow)
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    ,
    .rd_level       (rd_level),
    .almost_empty   (almost_empty)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    logic [3:0] gtab [8];
    gtab = '{4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8, 4'h0};

    // 1: reset wins over rd_en
    rd_srstn = 1'b0;
    rd_en = 1'b1;
    wptr_gray_async = 4'd5;
    repeat (3) step();
    check_eq("rst_ptr", rd_ptr, 0);
    check_eq("rst_gray", rd_ptr_gray, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_uflow", underflow, 0);
    check_eq("rst_addr", rd_addr, 0);
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    check_eq("rst_level", rd_level, 0);
    check_eq("rst_ae", almost_empty, 1);
`endif

    // 2: two-flop sync latency then a single read
    rd_srstn = 1'b1;
    rd_en = 1'b0;
    wptr_gray_async = 4'd0;
    step();
    wptr_gray_async = 4'd1;
    step();
    check_eq("lat_n", empty, 1);
    step();
    check_eq("lat_n1", empty, 1);
    step();
    check_eq("lat_n2", empty, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq("rd1_ptr", rd_ptr, 1);
    check_eq("rd1_gray", rd_ptr_gray, 1);
    check_eq("rd1_empty", empty, 1);
    check_eq("rd1_valid", rd_valid, 1);
    step();
    check_eq("rd1_valid_drop", rd_valid, 0);
    check_eq("rd1_no_uflow", underflow, 0);

    // 3: underflow pulses while empty
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("uf_pulse", underflow, 1);
      check_eq("uf_ptr", rd_ptr, 1);
      check_eq("uf_valid", rd_valid, 0);
    end
    rd_en = 1'b0;
    step();
    check_eq("uf_clear", underflow, 0);

    // 4: full FIFO burst from a fresh reset (write bin 8 = Gray 1100)
    rd_srstn = 1'b0;
    wptr_gray_async = 4'd0;
    step();
    rd_srstn = 1'b1;
    wptr_gray_async = 4'hc;
    repeat (3) step();
    check_eq("burst_ne", empty, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("burst_addr", rd_addr, i);
      step();
      check_eq("burst_valid", rd_valid, 1);
      check_eq("burst_ptr", rd_ptr, i + 1);
      check_eq("burst_empty", empty, (i == 7) ? 1 : 0);
    end
    step();
    check_eq("burst_no9_valid", rd_valid, 0);
    check_eq("burst_no9_ptr", rd_ptr, 8);
    check_eq("burst_no9_uflow", underflow, 1);
    rd_en = 1'b0;

    // 5: wrap; write at bin 16 mod 16 = 0 shares low bits with read bin 8 but not the MSB
    wptr_gray_async = 4'h0;
    repeat (3) step();
    check_eq("wrap_ne", empty, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("wrap_gray", rd_ptr_gray, gtab[i]);
      check_eq("wrap_empty", empty, (i == 7) ? 1 : 0);
    end
    check_eq("wrap_ptr", rd_ptr, 0);
    rd_en = 1'b0;

`ifdef ASYNC_FIFO_RD_LEVEL_EN
    // 6: level and almost_empty, then reset mid-burst (write bin 5 = Gray 0111)
    rd_srstn = 1'b0;
    wptr_gray_async = 4'd0;
    step();
    rd_srstn = 1'b1;
    wptr_gray_async = 4'h7;
    repeat (3) step();
    check_eq("lvl_5", rd_level, 5);
    check_eq("lvl_ae5", almost_empty, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("lvl_dec", rd_level, 4 - i);
      check_eq("lvl_ae", almost_empty, (i == 2) ? 1 : 0);
    end
    rd_srstn = 1'b0;
    step();
    check_eq("lvl_rst", rd_level, 0);
    check_eq("lvl_rst_ae", almost_empty, 1);
    check_eq("lvl_rst_ptr", rd_ptr, 0);
    rd_srstn = 1'b1;
    rd_en = 1'b0;
`else
    // Mid-operation reset with rd_en held (write bin 5 = Gray 0111)
    rd_srstn = 1'b0;
    wptr_gray_async = 4'd0;
    step();
    rd_srstn = 1'b1;
    wptr_gray_async = 4'h7;
    repeat (3) step();
    rd_en = 1'b1;
    step();
    check_eq("mid_ptr1", rd_ptr, 1);
    rd_srstn = 1'b0;
    step();
    check_eq("mid_rst_ptr", rd_ptr, 0);
    check_eq("mid_rst_empty", empty, 1);
    check_eq("mid_rst_valid", rd_valid, 0);
    rd_srstn = 1'b1;
    rd_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
